// File: rtl/intra_s3substictrl.sv
// Intra stage-3 reference-substitution sequencer. It emits one substi_Opt word per reference
// line, left lines first and then top lines, and it requests r_b before the first line.
module intra_s3substictrl #(
  parameter int NBANK = 8,
  parameter int OPTW  = 3
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [1:0]  nT_log2,
  input  logic        is_cr,
  input  logic [15:0] avail_l,
  input  logic [15:0] avail_t,
  input  logic        avail_tl,
  input  logic [15:0] byp_l,
  input  logic [15:0] byp_t,
  output logic        busy,
  output logic        rb_req,
  output logic [5:0]  rb_idx,
  input  logic        rb_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] substi_Opt,
  output logic        line_side,
  output logic        line_idx,
  output logic        dc_fill,
  output logic        last,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SRCH   = 3'd1,
    S_RB     = 3'd2,
    S_EMIT_L = 3'd3,
    S_EMIT_T = 3'd4
  } state_t;

  state_t      r_state, w_nxt_state;
  logic [1:0]  r_nt;
  logic        r_cr, r_avtl;
  logic [15:0] r_avl, r_avt, r_bypl, r_bypt;

  logic        r_busy, r_valid, r_side, r_idx, r_last, r_done, r_rbreq, r_dc;
  logic [25:0] r_opt;
  logic [5:0]  r_rbidx;

  logic        w_busy, w_valid, w_side, w_idx, w_last, w_done, w_rbreq, w_dc_n;
  logic [25:0] w_opt;
  logic [5:0]  w_rbidx;
  logic        w_load, w_ld_side, w_ld_idx;

  logic [5:0]  w_u;
  logic        w_lps2;
  logic [5:0]  w_first;
  logic        w_any, w_hit, w_dc;

  // Builds one line word: opt0 sits in the MSBs, unused banks beyond the block carry 0.
  function automatic logic [25:0] line_word(
    input logic        side,
    input logic        idx,
    input logic [5:0]  u,
    input logic [5:0]  first,
    input logic        dc,
    input logic        cr,
    input logic        tl,
    input logic [15:0] avl,
    input logic [15:0] bypl,
    input logic [15:0] avt,
    input logic [15:0] bypt
  );
    logic [25:0] word;
    logic [4:0]  unit;
    logic [5:0]  s;
    logic        av, bp;
    logic [2:0]  op;
    word     = 26'd0;
    word[25] = cr;
    word[24] = side & ~idx & ~tl & ~dc;
    for (int i = 0; i < NBANK; i++) begin
      unit = {1'b0, idx, 3'(i)};
      s    = side ? (u + 6'd1 + {2'b00, unit[3:0]}) : {2'b00, unit[3:0]};
      av   = side ? avt[unit[3:0]]  : avl[unit[3:0]];
      bp   = side ? bypt[unit[3:0]] : bypl[unit[3:0]];
      if ({1'b0, unit} >= u) begin
        op = 3'd0;
      end else if (dc) begin
        op = 3'd4;
      end else if (av) begin
        op = bp ? 3'd1 : 3'd0;
      end else if (s < first) begin
        op = 3'd4;
      end else begin
        op = 3'd5;
      end
      word[(NBANK-1-i)*OPTW +: OPTW] = op;
    end
    return word;
  endfunction

  assign w_u    = 6'd2 << r_nt;
  assign w_lps2 = (r_nt == 2'd3);

  // Priority encoder over the scan order; lower scan indices overwrite higher ones.
  always_comb begin
    w_first = 6'd0;
    w_any   = 1'b0;
    w_hit   = 1'b0;
    for (int m = 15; m >= 0; m--) begin
      w_hit   = r_avt[m] && (6'(m) < w_u);
      w_first = w_hit ? (w_u + 6'd1 + 6'(m)) : w_first;
      w_any   = w_any | w_hit;
    end
    w_first = r_avtl ? w_u : w_first;
    w_any   = w_any | r_avtl;
    for (int j = 15; j >= 0; j--) begin
      w_hit   = r_avl[j] && (6'(j) < w_u);
      w_first = w_hit ? 6'(j) : w_first;
      w_any   = w_any | w_hit;
    end
    w_dc = ~w_any;
  end

  // Captures the block description when a start is accepted from IDLE.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_nt   <= 2'd0;
      r_cr   <= 1'b0;
      r_avtl <= 1'b0;
      r_avl  <= 16'd0;
      r_avt  <= 16'd0;
      r_bypl <= 16'd0;
      r_bypt <= 16'd0;
    end else if (r_state == S_IDLE && start) begin
      r_nt   <= nT_log2;
      r_cr   <= is_cr;
      r_avtl <= avail_tl;
      r_avl  <= avail_l;
      r_avt  <= avail_t;
      r_bypl <= byp_l;
      r_bypt <= byp_t;
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_nxt_state = r_state;
    w_busy      = r_busy;
    w_valid     = r_valid;
    w_side      = r_side;
    w_idx       = r_idx;
    w_last      = r_last;
    w_opt       = r_opt;
    w_done      = 1'b0;
    w_rbreq     = r_rbreq;
    w_rbidx     = r_rbidx;
    w_dc_n      = r_dc;
    w_load      = 1'b0;
    w_ld_side   = 1'b0;
    w_ld_idx    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_state = S_SRCH;
          w_busy      = 1'b1;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_SRCH: begin
        w_dc_n  = w_dc;
        w_rbidx = w_first;
        if (w_dc || w_first == 6'd0) begin
          w_nxt_state = S_EMIT_L;
          w_load      = 1'b1;
        end else begin
          w_rbreq     = 1'b1;
          w_nxt_state = S_RB;
        end
      end
      S_RB: begin
        if (rb_ack) begin
          w_rbreq     = 1'b0;
          w_nxt_state = S_EMIT_L;
          w_load      = 1'b1;
        end else begin
          w_nxt_state = S_RB;
        end
      end
      S_EMIT_L: begin
        if (r_valid && out_ready) begin
          w_load = 1'b1;
          if (r_idx == w_lps2) begin
            w_ld_side   = 1'b1;
            w_nxt_state = S_EMIT_T;
          end else begin
            w_ld_idx = 1'b1;
          end
        end else begin
          w_nxt_state = S_EMIT_L;
        end
      end
      S_EMIT_T: begin
        if (r_valid && out_ready) begin
          if (r_last) begin
            w_done      = 1'b1;
            w_busy      = 1'b0;
            w_valid     = 1'b0;
            w_side      = 1'b0;
            w_idx       = 1'b0;
            w_last      = 1'b0;
            w_opt       = 26'd0;
            w_dc_n      = 1'b0;
            w_rbidx     = 6'd0;
            w_nxt_state = S_IDLE;
          end else begin
            w_load    = 1'b1;
            w_ld_side = 1'b1;
            w_ld_idx  = 1'b1;
          end
        end else begin
          w_nxt_state = S_EMIT_T;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
    if (w_load) begin
      w_valid = 1'b1;
      w_side  = w_ld_side;
      w_idx   = w_ld_idx;
      w_last  = w_ld_side & (w_ld_idx == w_lps2);
      w_opt   = line_word(w_ld_side, w_ld_idx, w_u, w_first, w_dc, r_cr, r_avtl,
                          r_avl, r_bypl, r_avt, r_bypt);
    end else begin
      w_valid = w_valid;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_side  <= 1'b0;
      r_idx   <= 1'b0;
      r_last  <= 1'b0;
      r_opt   <= 26'd0;
      r_done  <= 1'b0;
      r_rbreq <= 1'b0;
      r_rbidx <= 6'd0;
      r_dc    <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_busy  <= w_busy;
      r_valid <= w_valid;
      r_side  <= w_side;
      r_idx   <= w_idx;
      r_last  <= w_last;
      r_opt   <= w_opt;
      r_done  <= w_done;
      r_rbreq <= w_rbreq;
      r_rbidx <= w_rbidx;
      r_dc    <= w_dc_n;
    end
  end

  assign busy       = r_busy;
  assign rb_req     = r_rbreq;
  assign rb_idx     = r_rbidx;
  assign out_valid  = r_valid;
  assign substi_Opt = r_opt;
  assign line_side  = r_side;
  assign line_idx   = r_idx;
  assign dc_fill    = r_dc;
  assign last       = r_last;
  assign done       = r_done;

endmodule
